// File: rtl/dot_product_engine_pkg.sv
// Shared types and helpers for the dot-product engine: FSM state encoding
// and the signed saturation bounds used by the optional clamp (DOT_SATURATE_EN).
package dot_product_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_RESULT = 2'd3
    } state_e;

    localparam int MAX_SAT_WIDTH = 256;

    // Largest positive value of a signed w-bit number, zero-padded; callers truncate.
    function automatic logic [MAX_SAT_WIDTH-1:0] sat_max(input int w);
        logic [MAX_SAT_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < w - 1; i++) begin
            m[i] = 1'b1;
        end
        return m;
    endfunction

    // Most negative signed w-bit value; bits above w-1 are don't-care after truncation.
    function automatic logic [MAX_SAT_WIDTH-1:0] sat_min(input int w);
        logic [MAX_SAT_WIDTH-1:0] m;
        m = '1;
        for (int i = 0; i < w - 1; i++) begin
            m[i] = 1'b0;
        end
        return m;
    endfunction

    function automatic logic add_overflow(input logic sign_a, input logic sign_b,
                                          input logic sign_sum);
        return (sign_a == sign_b) && (sign_sum != sign_a);
    endfunction

endpackage

// File: rtl/dot_product_engine_mac.sv
// Combinational multiply-accumulate step: sign-extend, multiply, add, and
// (with DOT_SATURATE_EN) clamp to the signed accumulator range on overflow.
module dot_product_engine_mac
    import dot_product_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 72
) (
    input  logic [ACC_WIDTH-1:0]  acc_in,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic [ACC_WIDTH-1:0]  sum_out,
    output logic                  sat_out
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    logic signed [PROD_WIDTH-1:0] a_ext;
    logic signed [PROD_WIDTH-1:0] b_ext;
    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic        [ACC_WIDTH-1:0]  raw_sum;

    always_comb begin
        a_ext    = PROD_WIDTH'($signed(a_in));
        b_ext    = PROD_WIDTH'($signed(b_in));
        prod     = a_ext * b_ext;
        prod_ext = ACC_WIDTH'(prod);
        raw_sum  = acc_in + prod_ext;
    end

`ifdef DOT_SATURATE_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));

    logic ovf;

    // Overflow only when both addends share a sign the sum does not; clamp toward that sign.
    always_comb begin
        ovf     = add_overflow(acc_in[ACC_WIDTH-1], prod_ext[ACC_WIDTH-1],
                               raw_sum[ACC_WIDTH-1]);
        sat_out = ovf;
        sum_out = raw_sum;
        if (ovf) begin
            sum_out = acc_in[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    always_comb begin
        sum_out = raw_sum;
        sat_out = 1'b0;
    end
`endif

endmodule

// File: rtl/dot_product_engine.sv
// Dot-product engine: drives start_reading to both operand readers for VEC_LEN
// cycles, accumulates lock-stepped beats and holds one result on a valid/ready port.
// Optional clamping arithmetic and sticky sat_flag enabled by DOT_SATURATE_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for start
// ST_ISSUE  | start_reading asserted, VEC_LEN cycles; beats may arrive
// ST_DRAIN  | reads issued, accumulating remaining in-flight beats
// ST_RESULT | result_valid held until result_ready
module dot_product_engine
    import dot_product_engine_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int VEC_LEN    = 32,
    parameter int ACC_WIDTH  = 72
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  start_reading,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  busy,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [ACC_WIDTH-1:0]  result_data,
    output logic                  sat_flag
);

    localparam int CNT_WIDTH = $clog2(VEC_LEN + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(VEC_LEN - 1);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   issue_cnt_q, issue_cnt_d;
    logic [CNT_WIDTH-1:0]   recv_cnt_q, recv_cnt_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [ACC_WIDTH-1:0]   result_data_q, result_data_d;
    logic                   sat_q, sat_d;

    logic [ACC_WIDTH-1:0]   mac_sum;
    logic                   mac_sat;
    logic                   accept;
    logic                   last_beat;

    dot_product_engine_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .acc_in  (acc_q),
        .a_in    (a_data),
        .b_in    (b_data),
        .sum_out (mac_sum),
        .sat_out (mac_sat)
    );

    assign accept    = in_valid && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
    assign last_beat = accept && (recv_cnt_q == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            issue_cnt_q   <= '0;
            recv_cnt_q    <= '0;
            acc_q         <= '0;
            result_data_q <= '0;
            sat_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            issue_cnt_q   <= issue_cnt_d;
            recv_cnt_q    <= recv_cnt_d;
            acc_q         <= acc_d;
            result_data_q <= result_data_d;
            sat_q         <= sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start)                     state_d = ST_ISSUE;
            ST_ISSUE:  if (issue_cnt_q == LAST_CNT)   state_d = ST_DRAIN;
            ST_DRAIN:                                 state_d = ST_DRAIN;
            ST_RESULT: if (result_ready)              state_d = ST_IDLE;
            default:                                  state_d = ST_IDLE;
        endcase
        // With zero upstream latency the final beat lands while still issuing.
        if (last_beat) begin
            state_d = ST_RESULT;
        end
    end

    always_comb begin
        issue_cnt_d   = issue_cnt_q;
        recv_cnt_d    = recv_cnt_q;
        acc_d         = acc_q;
        result_data_d = result_data_q;
        sat_d         = sat_q;
        if ((state_q == ST_IDLE) && start) begin
            issue_cnt_d = '0;
            recv_cnt_d  = '0;
            acc_d       = '0;
            sat_d       = 1'b0;
        end
        if (state_q == ST_ISSUE) begin
            issue_cnt_d = issue_cnt_q + CNT_WIDTH'(1);
        end
        if (accept) begin
            acc_d      = mac_sum;
            recv_cnt_d = recv_cnt_q + CNT_WIDTH'(1);
            sat_d      = sat_q | mac_sat;
        end
        if (last_beat) begin
            result_data_d = mac_sum;
        end
    end

    always_comb begin
        start_reading = (state_q == ST_ISSUE);
        busy          = (state_q != ST_IDLE);
        result_valid  = (state_q == ST_RESULT);
        result_data   = result_data_q;
        sat_flag      = sat_q;
    end

endmodule

// File: tb/tb_dot_product_engine.sv
// Directed bench: a 32-bit engine fed by a one-cycle-latency reader model or
// driven directly, plus an 8-bit/16-bit engine for the overflow corner.
module tb_dot_product_engine;

    localparam int DW  = 32;
    localparam int VL  = 4;
    localparam int AW  = 72;
    localparam int DW8 = 8;
    localparam int AW8 = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, in_valid, result_ready;
    logic [DW-1:0] a_data, b_data;
    logic          start_reading, busy, result_valid, sat_flag;
    logic [AW-1:0] result_data;

    logic           start8, in_valid8, ready8;
    logic [DW8-1:0] a8, b8;
    logic           sr8, busy8, rv8, sat8;
    logic [AW8-1:0] rd8;

    logic signed [DW-1:0] va [4];
    logic signed [DW-1:0] vb [4];
    int   rd_idx;
    logic use_reader;
    logic sr_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dot_product_engine #(.DATA_WIDTH(DW), .VEC_LEN(VL), .ACC_WIDTH(AW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_reading(start_reading),
        .in_valid(in_valid), .a_data(a_data), .b_data(b_data), .busy(busy),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_data(result_data), .sat_flag(sat_flag)
    );

    dot_product_engine #(.DATA_WIDTH(DW8), .VEC_LEN(VL), .ACC_WIDTH(AW8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .start_reading(sr8),
        .in_valid(in_valid8), .a_data(a8), .b_data(b8), .busy(busy8),
        .result_valid(rv8), .result_ready(ready8),
        .result_data(rd8), .sat_flag(sat8)
    );

    task automatic check(input string tag, input logic signed [127:0] got,
                         input logic signed [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reader model: one element per start_reading cycle, data valid one cycle later.
    initial begin
        forever begin
            @(negedge clk);
            sr_s = start_reading;
            @(posedge clk);
            #1;
            if (use_reader) begin
                in_valid = sr_s;
                if (sr_s && rd_idx < 4) begin
                    a_data = va[rd_idx];
                    b_data = vb[rd_idx];
                    rd_idx++;
                end
            end
        end
    end

    task automatic run_reader_op(input string tag, input logic signed [127:0] exp);
        int sr_cnt, beats, last_beat, rv_cyc;
        sr_cnt = 0; beats = 0; last_beat = -100; rv_cyc = -1;
        rd_idx = 0;
        use_reader = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 30 && rv_cyc < 0; c++) begin
            @(negedge clk);
            if (start_reading) sr_cnt++;
            if (in_valid) begin
                beats++;
                last_beat = c;
            end
            if (result_valid) rv_cyc = c;
        end
        check({tag, "_issue_cycles"}, sr_cnt, 4);
        check({tag, "_beats"}, beats, 4);
        check({tag, "_rv_latency"}, rv_cyc - last_beat, 1);
        check({tag, "_data"}, $signed(result_data), exp);
    endtask

    task automatic accept_result(input string tag);
        tick();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check({tag, "_rv_after_ready"}, result_valid, 0);
        check({tag, "_busy_after_ready"}, busy, 0);
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic signed [127:0] exp, input logic exp_sat);
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid8 = 1'b1;
            a8 = a;
            b8 = b;
            tick();
        end
        in_valid8 = 1'b0;
        check({tag, "_rv"}, rv8, 1);
        check({tag, "_data"}, $signed(rd8), exp);
        check({tag, "_sat"}, sat8, exp_sat);
        ready8 = 1'b1;
        tick();
        ready8 = 1'b0;
        check({tag, "_idle"}, busy8, 0);
    endtask

    initial begin
        logic signed [127:0] exp_wrap;
        logic                exp_sat;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; result_ready = 1'b0;
        a_data = '0; b_data = '0;
        start8 = 1'b0; in_valid8 = 1'b0; ready8 = 1'b0; a8 = '0; b8 = '0;
        use_reader = 1'b0; rd_idx = 0;
        tick(); tick();
        rst_n = 1'b1;
        check("rst_start_reading", start_reading, 0);
        check("rst_busy", busy, 0);
        check("rst_result_valid", result_valid, 0);
        check("rst_result_data", $signed(result_data), 0);
        check("rst_sat", sat_flag, 0);
        check("rst8_data", $signed(rd8), 0);
        tick();

        // Test 1: 1*5+2*6+3*7+4*8 = 70
        va = '{1, 2, 3, 4};
        vb = '{5, 6, 7, 8};
        run_reader_op("t1", 70);
        accept_result("t1");
        check("t1_no_sat", sat_flag, 0);

        // Test 2: negated A gives -70
        va = '{-1, -2, -3, -4};
        run_reader_op("t2", -70);
        accept_result("t2");

        // Test 3: hold ready low; start during RESULT must not be queued
        va = '{1, 2, 3, 4};
        run_reader_op("t3", 70);
        for (int i = 0; i < 5; i++) begin
            tick();
            start = (i == 1);
            check("t3_hold_rv", result_valid, 1);
            check("t3_hold_data", $signed(result_data), 70);
        end
        start = 1'b0;
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        check("t3_idle_rv", result_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_no_queued_start", busy, 0);
            check("t3_no_reads", start_reading, 0);
        end

        // Test 4: reset on the second ISSUE cycle, then a clean op
        rd_idx = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("t4_in_issue", start_reading, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t4_rst_start_reading", start_reading, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_rv", result_valid, 0);
        check("t4_rst_data", $signed(result_data), 0);
        check("t4_rst_sat", sat_flag, 0);
        tick(); tick(); tick();
        run_reader_op("t4", 70);
        accept_result("t4");

        // Test 6: zero-latency direct drive, 2*7-3*8-4*9+5*10 = 4
        use_reader = 1'b0;
        tick(); tick();
        in_valid = 1'b0;
        va = '{2, -3, 4, 5};
        vb = '{7, 8, -9, 10};
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            a_data = va[k];
            b_data = vb[k];
            if (k == 3) check("t6_issue_at_last_beat", start_reading, 1);
            tick();
        end
        check("t6_rv", result_valid, 1);
        check("t6_sr_off", start_reading, 0);
        check("t6_data", $signed(result_data), 4);
        a_data = 32'd100;
        b_data = 32'd100;
        tick();
        in_valid = 1'b0;
        check("t6_extra_beat_ignored", $signed(result_data), 4);
        tick();
        check("t6_sr_still_off", start_reading, 0);
        accept_result("t6");

        // Test 5: 4*127*127 = 64516 overflows signed 16 bits
`ifdef DOT_SATURATE_EN
        exp_wrap = 32767;
        exp_sat  = 1'b1;
`else
        exp_wrap = -1020;
        exp_sat  = 1'b0;
`endif
        run8("t5_overflow", 8'd127, 8'd127, exp_wrap, exp_sat);
        run8("t5_sat_cleared", 8'd1, 8'd1, 4, 1'b0);
        run8("t5_neg", 8'hFF, 8'd3, -12, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
